spi_slave: RTL and testbench

SPI target (slave) end of the SoC SPI link. It receives 8-bit frames from an external SPI master on ss/sck/mosi and returns bytes on miso, all in CPOL/CPHA modes 0-3. sck, ss and mosi are oversampled in the clk domain through synchronizers, with edge detection on the synchronized sck. It presents a simple byte-level handshake toward a register wrapper on the SoC data bus.

---
 rtl/spi_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI target, modes 0-3, byte handshake toward a register wrapper
// Optional LSB-first framing with lsb_first port when SPI_SLAVE_LSB_FIRST_EN is defined.
`timescale 1ns/1ps
module spi_slave #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  TX_IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_data_valid,
    output logic [7:0] rx_data,
    output logic       rx_full,
    input  logic       rx_read,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       err_clr,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic       lsb_first,
`endif
    output logic       busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   cpol_l;
    logic                   cpha_l;
    logic                   lsb_l;
    logic [7:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_hold;
    logic                   tx_full;
    logic [2:0]             bit_cnt;

    logic       ss_s, sck_s, mosi_s;
    logic       sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic       frame_start, byte_done, frame_load, tx_accept;
    logic [7:0] rx_next, tx_shifted, load_byte;

    // Synchronizers idle at ss=1, sck=cpol so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sck_sync  <= {SYNC_STAGES{cpol}};
            mosi_sync <= '0;
            sck_prev  <= cpol;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_s;
        end
    end

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_edge    = sck_s ^ sck_prev;
    assign lead_edge   = sck_edge & (sck_prev == cpol_l);
    assign trail_edge  = sck_edge & (sck_s == cpol_l);
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;

    assign rx_next    = lsb_l ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};
    assign tx_shifted = lsb_l ? {1'b0, tx_shift[7:1]}   : {tx_shift[6:0], 1'b0};

    assign frame_start = (state == IDLE) && !ss_s;
    assign byte_done   = (state == ACTIVE) && !ss_s && sample_edge && (bit_cnt == 3'd7);
    assign frame_load  = frame_start || byte_done;
    assign tx_accept   = tx_data_valid && !tx_full;
    assign load_byte   = tx_full ? tx_hold : TX_IDLE_BYTE;

    assign tx_ready = !tx_full;
    assign miso_oe  = busy;
    assign miso     = lsb_l ? tx_shift[0] : tx_shift[7];

`ifdef SPI_SLAVE_LSB_FIRST_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            lsb_l <= 1'b0;
        else if (frame_start)
            lsb_l <= lsb_first;
    end
`else
    assign lsb_l = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cpol_l        <= 1'b0;
            cpha_l        <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            tx_hold       <= '0;
            tx_full       <= 1'b0;
            bit_cnt       <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_full       <= 1'b0;
            rx_overrun    <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            if (rx_read)
                rx_full <= 1'b0;
            if (err_clr) begin
                rx_overrun  <= 1'b0;
                tx_underrun <= 1'b0;
            end
            if (tx_accept) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!ss_s) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        cpol_l  <= cpol;
                        cpha_l  <= cpha;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    // Deselect takes priority over any sck edge seen in the same cycle.
                    if (ss_s) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt       <= '0;
                            rx_data       <= rx_next;
                            rx_data_valid <= 1'b1;
                            rx_full       <= 1'b1;
                            if (rx_full && !rx_read)
                                rx_overrun <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (shift_edge && (bit_cnt != 3'd0)) begin
                        tx_shift <= tx_shifted;
                    end
                end
                default: state <= IDLE;
            endcase

            // A write landing on an empty-register load goes to the holding register.
            if (frame_load) begin
                tx_shift <= load_byte;
                if (tx_full)
                    tx_full <= 1'b0;
                else
                    tx_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed and randomized bench for spi_slave with a transaction-level model
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       tx_data_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_read = 1'b0;
    logic       err_clr = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_data_valid, rx_full, rx_overrun, tx_underrun, busy;
    logic [7:0] rx_data;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    bit         m_hold_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_underrun = 1'b0;
    bit         m_overrun = 1'b0;
    bit         m_rx_full = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    int         m_pulses = 0;
    logic [7:0] exp_q[$];

    spi_slave #(.SYNC_STAGES(2), .TX_IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .ss(ss), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_full(rx_full),
        .rx_read(rx_read), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
        .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && rx_data_valid)
            pulses <= pulses + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] m_load();
        if (m_hold_full) begin
            m_hold_full = 1'b0;
            return m_hold;
        end
        m_underrun = 1'b1;
        return 8'hFF;
    endfunction

    task automatic m_complete(input logic [7:0] b, input bit coinc);
        if (m_rx_full && !coinc)
            m_overrun = 1'b1;
        m_rx_full = 1'b1;
        m_rx_data = b;
        m_pulses++;
    endtask

    task automatic write_tx(input logic [7:0] b);
        chk("tx_ready_before_write", 32'(tx_ready), 32'(!m_hold_full));
        tx_data = b;
        tx_data_valid = 1'b1;
        wait_n(1);
        tx_data_valid = 1'b0;
        m_hold_full = 1'b1;
        m_hold = b;
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        wait_n(1);
        rx_read = 1'b0;
        m_rx_full = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
        m_underrun = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic read_hook();
        wait_n(2);
        rx_read = 1'b1;
        wait_n(1);
        rx_read = 1'b0;
        chk("valid_after_coincident_read", 32'(rx_data_valid), 32'd1);
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi, input int nbits, input bit rd);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[7-i];
                wait_n(HALF);
                mi = {mi[6:0], miso};
                sck = ~cpol;
                if (rd && i == nbits - 1) begin
                    read_hook();
                    wait_n(HALF - 3);
                end else begin
                    wait_n(HALF);
                end
                sck = cpol;
            end else begin
                wait_n(HALF);
                sck = ~cpol;
                mosi = mo[7-i];
                wait_n(HALF);
                mi = {mi[6:0], miso};
                sck = cpol;
                if (rd && i == nbits - 1)
                    read_hook();
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(m_rx_data));
        chk({tag, "_rx_full"}, 32'(rx_full), 32'(m_rx_full));
        chk({tag, "_rx_overrun"}, 32'(rx_overrun), 32'(m_overrun));
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'(m_underrun));
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'(!m_hold_full));
        chk({tag, "_pulses"}, 32'(pulses), 32'(m_pulses));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_miso_oe_idle"}, 32'(miso_oe), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_rx_valid"}, 32'(rx_data_valid), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rx_full"}, 32'(rx_full), 32'd0);
        chk({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic frame(input string tag, input logic [1:0] mode, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1, input bit rd_last);
        logic [7:0] mi, b, e;
        bit coinc;
        cpol = mode[1];
        cpha = mode[0];
        sck = mode[1];
        wait_n(4);
        ss = 1'b0;
        exp_q.push_back(m_load());
        wait_n(HALF);
        chk({tag, "_busy_active"}, 32'(busy), 32'd1);
        chk({tag, "_miso_oe_active"}, 32'(miso_oe), 32'd1);
        for (int k = 0; k < nb; k++) begin
            b = (k == 0) ? b0 : b1;
            coinc = rd_last && (k == nb - 1);
            spi_byte(b, mi, 8, coinc);
            e = exp_q.pop_front();
            chk({tag, "_master_rx"}, 32'(mi), 32'(e));
            m_complete(b, coinc);
            exp_q.push_back(m_load());
        end
        wait_n(HALF);
        ss = 1'b1;
        wait_n(HALF);
        exp_q.delete();
        check_state(tag);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] rb0, rb1;
        logic [1:0] rmode;
        int rnb;

        wait_n(3);
        check_reset("reset");
        rst_n = 1'b1;
        wait_n(2);

        write_tx(8'hA5);
        frame("mode0", 2'd0, 1, 8'h3C, 8'h00, 1'b0);
        do_read();
        do_clr();

        for (int m = 1; m < 4; m++) begin
            write_tx(8'h81);
            frame($sformatf("mode%0d", m), 2'(m), 1, 8'h7E, 8'h00, 1'b0);
            do_read();
            do_clr();
        end

        frame("two_byte", 2'd0, 2, 8'h11, 8'h22, 1'b0);
        do_clr();
        check_state("after_err_clr");
        do_read();

        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        wait_n(4);
        ss = 1'b0;
        void'(m_load());
        wait_n(HALF);
        spi_byte(8'hF0, mi, 5, 1'b0);
        wait_n(HALF);
        ss = 1'b1;
        wait_n(6);
        chk("partial_miso_oe", 32'(miso_oe), 32'd0);
        check_state("partial");
        frame("after_partial", 2'd0, 1, 8'h0F, 8'h00, 1'b0);
        do_read();
        do_clr();

        cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        wait_n(4);
        ss = 1'b0;
        void'(m_load());
        wait_n(HALF);
        spi_byte(8'hC3, mi, 3, 1'b0);
        rst_n = 1'b0;
        wait_n(1);
        rst_n = 1'b1;
        ss = 1'b1;
        check_reset("mid_reset");
        m_hold_full = 1'b0; m_underrun = 1'b0; m_overrun = 1'b0;
        m_rx_full = 1'b0; m_rx_data = 8'h00;
        wait_n(HALF);
        frame("after_reset", 2'd0, 1, 8'h5A, 8'h00, 1'b0);
        do_read();
        do_clr();

        frame("coincident_read", 2'd0, 2, 8'h3C, 8'hC3, 1'b1);
        do_read();
        do_clr();

        for (int it = 0; it < 12; it++) begin
            rmode = 2'($urandom_range(0, 3));
            rb0 = 8'($urandom);
            rb1 = 8'($urandom);
            rnb = $urandom_range(1, 2);
            if (!m_hold_full && $urandom_range(0, 1) == 1)
                write_tx(8'($urandom));
            if ($urandom_range(0, 1) == 1)
                do_read();
            frame($sformatf("rand%0d", it), rmode, rnb, rb0, rb1, 1'b0);
            if ($urandom_range(0, 1) == 1)
                do_clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
